// File: rtl/collision_pkg.sv
// Shared types and constants for the collision monitor and its hazard matcher.
package collision_pkg;

  typedef enum logic [1:0] {
    ST_PLAYING,
    ST_GRACE,
    ST_GAME_OVER,
    ST_WON
  } state_t;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] COL_GREEN = 3'b010;
  localparam logic [2:0] COL_RED   = 3'b100;

endpackage

// File: rtl/collision_monitor_hazard_match.sv
// Compares one pixel colour against the hazard colour list and reports the
// lowest-numbered matching entry.
module hazard_match
  import collision_pkg::*;
#(
  parameter int COLOUR_W    = 3,
  parameter int NUM_HAZARDS = 2,
  parameter int IDX_W       = 1,
  parameter logic [NUM_HAZARDS*COLOUR_W-1:0] HAZARD_COLOURS = {COL_RED, COL_GREEN}
) (
  input  logic [COLOUR_W-1:0] colour,
  output logic                match,
  output logic [IDX_W-1:0]    index
);

  // Walk from the top entry down so the lowest matching index is the one left.
  always_comb begin
    match = 1'b0;
    index = '0;
    for (int i = NUM_HAZARDS - 1; i >= 0; i--) begin
      if (colour == HAZARD_COLOURS[i*COLOUR_W +: COLOUR_W]) begin
        match = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/collision_monitor.sv
// Collision/goal monitor: debounces hazard pixels into hits, tracks lives with a
// post-hit grace window, and flags a win at the right screen edge.
module collision_monitor
  import collision_pkg::*;
#(
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int COLOUR_W    = 3,
  parameter int NUM_HAZARDS = 2,
  parameter logic [NUM_HAZARDS*COLOUR_W-1:0] HAZARD_COLOURS = {COL_RED, COL_GREEN},
  parameter int END_X         = SCREEN_W - 6,
  parameter int HIT_THRESHOLD = 2,
  parameter int LIVES         = 3,
  parameter int GRACE_CYCLES  = 60
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sample_valid,
  input  logic [X_W-1:0]       x_coord,
  input  logic [Y_W-1:0]       y_coord,
  input  logic [COLOUR_W-1:0]  colour,
  input  logic                 restart,
  output logic                 hit_pulse,
  output logic [X_W-1:0]       hit_x,
  output logic [Y_W-1:0]       hit_y,
  output logic [((NUM_HAZARDS > 1) ? $clog2(NUM_HAZARDS) : 1)-1:0] hit_index,
  output logic [$clog2(LIVES+1)-1:0] lives_left,
  output logic                 invulnerable,
  output logic                 collided,
  output logic                 reached_screen_end
);

  localparam int IDX_W   = (NUM_HAZARDS > 1) ? $clog2(NUM_HAZARDS) : 1;
  localparam int LIVES_W = $clog2(LIVES + 1);
  localparam int RUN_W   = $clog2(HIT_THRESHOLD + 1);
  localparam int GRACE_W = $clog2(GRACE_CYCLES + 1);

  localparam logic [X_W-1:0]     END_X_V   = X_W'(END_X);
  localparam logic [RUN_W-1:0]   THRESH_V  = RUN_W'(HIT_THRESHOLD);
  localparam logic [LIVES_W-1:0] LIVES_V   = LIVES_W'(LIVES);
  localparam logic [GRACE_W-1:0] GRACE_V   = GRACE_W'(GRACE_CYCLES);

  state_t             r_state, w_state;
  logic [RUN_W-1:0]   r_run_cnt, w_run_cnt, w_run_inc;
  logic [GRACE_W-1:0] r_grace_cnt, w_grace_cnt;
  logic [LIVES_W-1:0] r_lives, w_lives;
  logic [X_W-1:0]     r_hit_x, w_hit_x;
  logic [Y_W-1:0]     r_hit_y, w_hit_y;
  logic [IDX_W-1:0]   r_hit_index, w_hit_index;
  logic               r_hit_pulse, w_hit_pulse;
  logic               r_invulnerable, r_collided, r_won;
  logic               w_match;
  logic [IDX_W-1:0]   w_index;
  logic               w_at_end;

  hazard_match #(
    .COLOUR_W      (COLOUR_W),
    .NUM_HAZARDS   (NUM_HAZARDS),
    .IDX_W         (IDX_W),
    .HAZARD_COLOURS(HAZARD_COLOURS)
  ) u_hazard_match (
    .colour(colour),
    .match (w_match),
    .index (w_index)
  );

  assign w_at_end  = sample_valid && (x_coord >= END_X_V);
  assign w_run_inc = (r_run_cnt == THRESH_V) ? r_run_cnt : r_run_cnt + RUN_W'(1);

  always_comb begin
    w_state     = r_state;
    w_run_cnt   = r_run_cnt;
    w_grace_cnt = r_grace_cnt;
    w_lives     = r_lives;
    w_hit_x     = r_hit_x;
    w_hit_y     = r_hit_y;
    w_hit_index = r_hit_index;
    w_hit_pulse = 1'b0;
    unique case (r_state)
      ST_PLAYING: begin
        if (sample_valid) begin
          // A completed hit takes precedence over a win on the same sample.
          if (w_match && (w_run_inc == THRESH_V)) begin
            w_hit_pulse = 1'b1;
            w_hit_x     = x_coord;
            w_hit_y     = y_coord;
            w_hit_index = w_index;
            w_lives     = r_lives - LIVES_W'(1);
            w_run_cnt   = '0;
            if (r_lives == LIVES_W'(1)) begin
              w_state = ST_GAME_OVER;
            end else begin
              w_state     = ST_GRACE;
              w_grace_cnt = GRACE_V;
            end
          end else if (w_at_end) begin
            w_state   = ST_WON;
            w_run_cnt = '0;
          end else begin
            w_run_cnt = w_match ? w_run_inc : '0;
          end
        end
      end
      ST_GRACE: begin
        if (w_at_end) begin
          w_state     = ST_WON;
          w_grace_cnt = '0;
        end else begin
          w_grace_cnt = r_grace_cnt - GRACE_W'(1);
          if (r_grace_cnt == GRACE_W'(1)) w_state = ST_PLAYING;
        end
      end
      ST_GAME_OVER, ST_WON: begin
        if (restart) begin
          w_state     = ST_PLAYING;
          w_lives     = LIVES_V;
          w_run_cnt   = '0;
          w_grace_cnt = '0;
          w_hit_x     = '0;
          w_hit_y     = '0;
          w_hit_index = '0;
        end
      end
      default: w_state = ST_PLAYING;
    endcase
  end

  // Status flags are registered from the next state so every output is a flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= ST_PLAYING;
      r_run_cnt      <= '0;
      r_grace_cnt    <= '0;
      r_lives        <= LIVES_V;
      r_hit_x        <= '0;
      r_hit_y        <= '0;
      r_hit_index    <= '0;
      r_hit_pulse    <= 1'b0;
      r_invulnerable <= 1'b0;
      r_collided     <= 1'b0;
      r_won          <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_run_cnt      <= w_run_cnt;
      r_grace_cnt    <= w_grace_cnt;
      r_lives        <= w_lives;
      r_hit_x        <= w_hit_x;
      r_hit_y        <= w_hit_y;
      r_hit_index    <= w_hit_index;
      r_hit_pulse    <= w_hit_pulse;
      r_invulnerable <= (w_state == ST_GRACE);
      r_collided     <= (w_state == ST_GAME_OVER);
      r_won          <= (w_state == ST_WON);
    end
  end

  assign hit_pulse          = r_hit_pulse;
  assign hit_x              = r_hit_x;
  assign hit_y              = r_hit_y;
  assign hit_index          = r_hit_index;
  assign lives_left         = r_lives;
  assign invulnerable       = r_invulnerable;
  assign collided           = r_collided;
  assign reached_screen_end = r_won;

endmodule
